// File: rtl/sr_latch.sv
// Synchronous SR storage cell with complementary outputs and defined/invalid status flags.
// Define SR_LATCH_SYNC_EN to pass S_i/R_i through 2-flop synchronizers (latency 3 edges instead of 1).
module sr_latch #(
  parameter logic RESET_Q = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       S_i,
  input  logic       R_i,
  output logic       Q_o,
  output logic       nQ_o,
  output logic       Defined_o,
  output logic       Invalid_o,
  output logic [1:0] state_o
);

  localparam logic [1:0] ST_RESET   = 2'b00;
  localparam logic [1:0] ST_SET     = 2'b01;
  localparam logic [1:0] ST_INVALID = 2'b10;

  localparam logic [1:0] ST_POR = RESET_Q ? ST_SET : ST_RESET;

  logic s_smp;
  logic r_smp;

`ifdef SR_LATCH_SYNC_EN
  logic [1:0] s_sync_q;
  logic [1:0] r_sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s_sync_q <= 2'b00;
      r_sync_q <= 2'b00;
    end else begin
      s_sync_q <= {s_sync_q[0], S_i};
      r_sync_q <= {r_sync_q[0], R_i};
    end
  end

  assign s_smp = s_sync_q[1];
  assign r_smp = r_sync_q[1];
`else
  assign s_smp = S_i;
  assign r_smp = R_i;
`endif

  logic [1:0] state_q, state_d;
  logic       q_q, q_d;
  logic       nq_q, nq_d;
  logic       defined_q, defined_d;
  logic       invalid_q, invalid_d;

  always_comb begin
    state_d   = state_q;
    defined_d = defined_q;
    invalid_d = 1'b0;
    unique case ({s_smp, r_smp})
      2'b00: begin
        // Leaving INVALID falls to RESET but stays undefined until a real command arrives.
        if (state_q == ST_INVALID) state_d = ST_RESET;
      end
      2'b01: begin
        state_d   = ST_RESET;
        defined_d = 1'b1;
      end
      2'b10: begin
        state_d   = ST_SET;
        defined_d = 1'b1;
      end
      default: begin
        state_d   = ST_INVALID;
        defined_d = 1'b0;
        invalid_d = 1'b1;
      end
    endcase
    q_d  = (state_d == ST_SET);
    nq_d = (state_d == ST_RESET);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_POR;
      q_q       <= RESET_Q;
      nq_q      <= ~RESET_Q;
      defined_q <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      nq_q      <= nq_d;
      defined_q <= defined_d;
      invalid_q <= invalid_d;
    end
  end

  assign Q_o       = q_q;
  assign nQ_o      = nq_q;
  assign Defined_o = defined_q;
  assign Invalid_o = invalid_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_sr_latch.sv
// Directed bench for sr_latch; outputs are compared as the packed word {Q, nQ, Defined, Invalid}.
module tb_sr_latch;

`ifdef SR_LATCH_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       s;
  logic       r;
  logic       q;
  logic       nq;
  logic       defined;
  logic       invalid;
  logic [1:0] state;

  int n_cmp;
  int n_err;

  sr_latch #(.RESET_Q(1'b0)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .S_i       (s),
    .R_i       (r),
    .Q_o       (q),
    .nQ_o      (nq),
    .Defined_o (defined),
    .Invalid_o (invalid),
    .state_o   (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got {Q,nQ,D,I}=%b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {q, nq, defined, invalid};
  endfunction

  // drive a pair at the falling edge and hold it for n rising edges, then settle past the edge
  task automatic drive(input logic s_v, input logic r_v, input int n);
    @(negedge clk);
    s = s_v;
    r = r_v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    s     = 1'b0;
    r     = 1'b0;
    rst_n = 1'b0;
    #12;
    check_eq("reset", outs(), 4'b0100);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1'b0, 1'b0, 2);
    check_eq("idle_after_reset", outs(), 4'b0100);

    drive(1'b0, 1'b1, LAT);
    check_eq("reset_cmd", outs(), 4'b0110);

    drive(1'b1, 1'b0, LAT);
    check_eq("set_cmd", outs(), 4'b1010);

    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1);
      check_eq($sformatf("hold_set_%0d", i), outs(), 4'b1010);
    end

    drive(1'b1, 1'b1, LAT);
    check_eq("invalid", outs(), 4'b0001);
    drive(1'b0, 1'b0, LAT);
    check_eq("leave_invalid_idle", outs(), 4'b0100);
    drive(1'b0, 1'b0, 2);
    check_eq("undefined_hold", outs(), 4'b0100);

    drive(1'b1, 1'b1, LAT);
    check_eq("invalid_again", outs(), 4'b0001);
    drive(1'b1, 1'b0, LAT);
    check_eq("leave_invalid_set", outs(), 4'b1010);
    drive(1'b1, 1'b1, LAT);
    drive(1'b0, 1'b1, LAT);
    check_eq("leave_invalid_reset", outs(), 4'b0110);

    // pulse that never spans a rising edge
    drive(1'b0, 1'b0, LAT);
    @(negedge clk);
    s = 1'b1;
    #2;
    s = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #1;
    check_eq("short_pulse_ignored", outs(), 4'b0110);

    // single-cycle set pulse: Q rises LAT edges after (and including) the sampling edge
    @(negedge clk);
    s = 1'b1;
    @(posedge clk);
    #1;
    check_eq("lat_edge_1", outs(), (LAT <= 1) ? 4'b1010 : 4'b0110);
    @(negedge clk);
    s = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("lat_edge_%0d", k), outs(), (k >= LAT) ? 4'b1010 : 4'b0110);
    end

    // asynchronous reset between edges while set
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_from_set", outs(), 4'b0100);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1'b1, 1'b1, LAT);
    check_eq("invalid_before_reset", outs(), 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_from_invalid", outs(), 4'b0100);

    // set presented at the edge that ends reset is processed normally
    @(negedge clk);
    s     = 1'b1;
    r     = 1'b0;
    rst_n = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    check_eq("set_on_reset_release", outs(), 4'b1010);

    drive(1'b0, 1'b0, 3);
    check_eq("final_hold", outs(), 4'b1010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
